fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the 16-entry instruction memory. It owns the program counter, drives the memory address, and captures the returned instruction into an IF/ID pipeline register. The decoder consumes that register through a valid/ready handshake. The block also supports branch/jump redirect with flush, a halt instruction and a fetch counter.

Parameters:
ADDR_W, 4, PC / instruction-memory address width (memory depth 2^ADDR_W).
INSTR_W, 16, instruction width.
HALT_INSTR, 16'hFFFF, encoding that stops sequential fetch.
CNT_W, 8, width of the saturating fetch counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  leave IDLE and begin fetching at the current PC.
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
redirect_pc  input  ADDR_W  redirect target address.
imem_addr  output  ADDR_W  address to instruction memory; equals pc.
imem_instr  input  INSTR_W  combinational instruction from memory, valid in the same cycle.
id_valid  output  1  IF/ID register holds a valid instruction.
id_ready  input  1  decoder accepts the IF/ID contents this cycle.
id_instr  output  INSTR_W  registered instruction.
id_pc  output  ADDR_W  address the instruction was fetched from.
halted  output  1  state == HALT.
fetch_count  output  CNT_W  instructions loaded into IF/ID, saturating.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - pc = 0, id_valid = 0, id_instr = 0, id_pc = 0, fetch_count = 0.
  - state = IDLE, halted = 0.
- imem_addr = pc at all times (combinational).
- Slot free: slot_free = !id_valid | id_ready.
- States IDLE, RUN, HALT:
  - IDLE: no fetch. start=1 -> RUN on the next edge. redirect_valid is ignored in IDLE.
  - RUN, fetch when slot_free:
    - id_instr <= imem_instr, id_pc <= pc, id_valid <= 1, fetch_count += 1 (saturating).
    - If imem_instr == HALT_INSTR: pc holds and state -> HALT. The halt word is still delivered downstream.
    - Otherwise pc <= pc + 1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - RUN, not slot_free (stall): pc, id_* and fetch_count all hold.
  - HALT: no fetch. id_valid clears after its handshake (id_valid & id_ready). start is ignored. Only a redirect exits HALT.
- Redirect (RUN or HALT), highest priority:
  - pc <= redirect_pc, id_valid <= 0 (flush, regardless of id_ready), state -> RUN. No fetch that cycle.
  - The first fetch from the target occurs on the next edge.
- Consume without refill (id_valid & id_ready, no fetch this cycle): id_valid <= 0.
- Latency and throughput:
  - An instruction addressed in cycle N appears on id_instr/id_valid after edge N+1.
  - With id_ready held at 1, throughput is 1 instruction per cycle.
- Mid-operation reset: all state returns to reset values immediately (asynchronous), and fetch resumes only after start.
- id_instr and id_pc are stable while id_valid & !id_ready.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALT);
  - default ADDR_W, INSTR_W, CNT_W;
  - HALT_INSTR.
- One natural sub-module, if_id_reg: the valid/ready IF/ID register with flush input, holding id_instr, id_pc and id_valid.
- The PC, FSM and counter stay in fetch_unit.

Test Plan:
- Reset with memory mem[i]=i, then start, id_ready=1 -> id_instr = 0,1,2,...,15 on consecutive cycles. id_pc matches each value. fetch_count = 16 after 16 fetches.
- Wrap: continue past pc=15 -> id_pc goes 15 then 0, and id_instr 16'h000F then 16'h0000.
- Stall: id_ready=0 for 3 cycles while id_instr=5 -> id_instr, id_pc and pc hold. On release, the next values are 6 and then 7, with no skipped or duplicated instruction.
- Redirect: redirect_valid=1, redirect_pc=10 while id_instr=3 -> id_valid=0 the next cycle, then id_instr=10, 11. Redirect also wins over a simultaneous fetch.
- Halt: place 16'hFFFF at mem[4] -> id_instr=16'hFFFF is delivered, then halted=1, pc=4 and id_valid drops after the handshake. start is ignored. A redirect to 0 resumes fetch with id_instr=0.
- Async reset mid-run: assert rst_n=0 between edges -> all outputs go to their reset values immediately. After release, no fetch occurs until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 16;
  localparam int CNT_W_DEF   = 8;
  localparam logic [15:0] HALT_INSTR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/ready handoff to the decoder with a flush input.
module if_id_reg #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic               ready,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);
  // Flush only drops valid; payload holds so it stays stable until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, the IDLE/RUN/HALT control and the fetch counter.
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic slot_free, redir, fetch, is_halt;

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign slot_free = !id_valid || id_ready;
  assign is_halt   = (imem_instr == HALT_INSTR);
  // Redirect beats any fetch in the same cycle and is meaningless before start.
  assign redir     = redirect_valid && (state != IDLE);
  assign fetch     = (state == RUN) && slot_free && !redir;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (redir) state_nx = RUN;
               else if (fetch && is_halt) state_nx = HALT;
      HALT:    if (redir) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nx;
      if (redir)
        pc <= redirect_pc;
      else if (fetch && !is_halt)
        pc <= pc + ADDR_W'(1);
      if (fetch && (fetch_count != {CNT_W{1'b1}}))
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redir),
    .load    (fetch),
    .ready   (id_ready),
    .instr_d (imem_instr),
    .pc_d    (pc),
    .valid   (id_valid),
    .instr   (id_instr),
    .pc      (id_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a cycle-level behavioural model.
module tb_fetch_unit;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [15:0] id_instr;
  logic [3:0]  id_pc;
  logic        halted;
  logic [7:0]  fetch_count;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state, m_pc, m_idpc, m_cnt;
  bit m_valid;
  logic [15:0] m_instr;

  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 0; m_idpc = 0; m_cnt = 0; m_valid = 0; m_instr = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(imem_addr),   32'(m_pc));
    chk({tag, ".valid"}, 32'(id_valid),    32'(m_valid));
    chk({tag, ".instr"}, 32'(id_instr),    32'(m_instr));
    chk({tag, ".idpc"},  32'(id_pc),       32'(m_idpc));
    chk({tag, ".halt"},  32'(halted),      32'(m_state == M_HALT));
    chk({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
  endtask

  // Advance one clock: apply the spec rules to the model, then compare after the edge.
  task automatic step(input string tag);
    logic [15:0] w;
    if (m_state != M_IDLE && redirect_valid) begin
      m_pc = int'(redirect_pc); m_valid = 0; m_state = M_RUN;
    end else if (m_state == M_IDLE) begin
      if (start) m_state = M_RUN;
    end else if (m_state == M_RUN && (!m_valid || id_ready)) begin
      w = mem[m_pc];
      m_instr = w; m_idpc = m_pc; m_valid = 1;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (w == 16'hFFFF) m_state = M_HALT;
      else m_pc = (m_pc + 1) % 16;
    end else if (m_valid && id_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_until_instr(input logic [15:0] target, input string tag);
    int n = 0;
    while (!(m_valid && m_instr == target) && n < 40) begin
      step(tag);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $error("FAIL %s: timeout waiting for instr %0h, observed %0h", tag, target, id_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // idle: no fetch without start, redirect ignored
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    step("idle_redir");
    redirect_valid = 1'b0;
    step("idle");

    // sequential fetch 0..15 then wrap
    start = 1'b1; step("start"); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step("seq");
      chk("seq.val", 32'(id_instr), 32'(i));
    end
    chk("cnt16", 32'(fetch_count), 32'd16);
    step("wrap"); chk("wrap.pc", 32'(id_pc), 32'd0);
    step("wrap1");

    // stall while holding instruction 5
    run_until_instr(16'd5, "to5");
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.instr", 32'(id_instr), 32'd5);
      chk("stall.pc", 32'(imem_addr), 32'd6);
    end
    id_ready = 1'b1;
    step("rel6"); chk("rel6.instr", 32'(id_instr), 32'd6);
    step("rel7"); chk("rel7.instr", 32'(id_instr), 32'd7);

    // redirect to 10 while holding 3
    run_until_instr(16'd3, "to3");
    redirect_valid = 1'b1; redirect_pc = 4'd10;
    step("redir"); chk("redir.flush", 32'(id_valid), 32'd0);
    redirect_valid = 1'b0;
    step("tgt10"); chk("tgt10", 32'(id_instr), 32'd10);
    step("tgt11"); chk("tgt11", 32'(id_instr), 32'd11);

    // halt word at address 4
    mem[4] = 16'hFFFF;
    redirect_valid = 1'b1; redirect_pc = 4'd0; step("redir0"); redirect_valid = 1'b0;
    run_until_instr(16'hFFFF, "tohalt");
    chk("halt.pc", 32'(imem_addr), 32'd4);
    chk("halt.flag", 32'(halted), 32'd1);
    step("halt.hs"); chk("halt.drop", 32'(id_valid), 32'd0);
    start = 1'b1; step("halt.start"); step("halt.start2"); start = 1'b0;
    chk("halt.stay", 32'(halted), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 4'd0; step("resume.redir"); redirect_valid = 1'b0;
    step("resume"); chk("resume.instr", 32'(id_instr), 32'd0);

    // randomized traffic; long enough to saturate the counter
    for (int c = 0; c < 400; c++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 4'($urandom);
      start          = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0)
        mem[$urandom_range(0, 15)] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      step("rand");
    end
    redirect_valid = 1'b0; start = 1'b0; id_ready = 1'b1;

    // asynchronous reset between edges
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 16'h100);
    redirect_valid = 1'b1; redirect_pc = 4'd2; step("pre_rst"); redirect_valid = 1'b0;
    step("pre_rst1");
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("post_rst"); step("post_rst1");
    start = 1'b1; step("post_start"); start = 1'b0;
    step("post_f0"); chk("post_f0.instr", 32'(id_instr), 32'h100);
    step("post_f1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
